// File: rtl/padding_reader_l10_pkg.sv
// padding_reader_l10_pkg: shared FSM encoding, default geometry and width constants.
package padding_reader_l10_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;
    localparam int N_ADDER_TREE_DEF = 16;
    localparam int FM_W_DEF = 14;
    localparam int FM_H_DEF = 14;
    localparam int PAD_DEF = 1;
    localparam int PW = FM_W_DEF + 2 * PAD_DEF;
    localparam int PH = FM_H_DEF + 2 * PAD_DEF;
    localparam int DW = N_ADDER_TREE_DEF * 16;
    function automatic int grid_dim(input int n, input int p);
        return n + 2 * p;
    endfunction
endpackage

// File: rtl/mux_padding_2_1_L10_L16.sv
// mux_padding_2_1_L10_L16: zero-forcing 2:1 mux for the padded output word.
module mux_padding_2_1_L10_L16 #(
    parameter int W = 256
) (
    input  logic [W-1:0] din,
    input  logic         sel,
    output logic [W-1:0] dout
);
    assign dout = sel ? '0 : din;
endmodule

// File: rtl/padding_reader_l10.sv
// padding_reader_l10: raster read sequencer for the padded layer-10 feature map.
// Optional macro PAD_RUNTIME_BYPASS_EN adds pad_bypass to scan only the interior.
module padding_reader_l10
    import padding_reader_l10_pkg::*;
#(
    parameter int N_adder_tree = N_ADDER_TREE_DEF,
    parameter int FM_W = FM_W_DEF,
    parameter int FM_H = FM_H_DEF,
    parameter int PAD = PAD_DEF,
    parameter int ADDR_W = 8,
    parameter int BRAM_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
`ifdef PAD_RUNTIME_BYPASS_EN
    input  logic                      pad_bypass,
`endif
    output logic                      bram_rd_en,
    output logic [ADDR_W-1:0]         bram_rd_addr,
    input  logic [N_adder_tree*16-1:0] BRAM_out_without_padding,
    output logic [N_adder_tree*16-1:0] BRAM_out,
    output logic                      out_valid,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);
    localparam int GW = grid_dim(FM_W, PAD);
    localparam int GH = grid_dim(FM_H, PAD);
    localparam int WD = N_adder_tree * 16;
    localparam int CW = $clog2((GW > GH ? GW : GH) + 1);
    localparam int LW = $clog2(BRAM_LAT + 1);

    state_t state, state_n;
    logic [CW-1:0] r, c, pe, wl, hl;
    logic [LW-1:0] dc;
    logic [ADDR_W-1:0] nxt_addr, held_addr;
    logic [BRAM_LAT-1:0] pad_dl, vld_dl, lst_dl;
    logic byp_q, scan, is_pad, c_end, r_end, last_pos;

`ifdef PAD_RUNTIME_BYPASS_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) byp_q <= 1'b0;
        else if (state == IDLE && start) byp_q <= pad_bypass;
`else
    assign byp_q = 1'b0;
`endif

    // bypass collapses the grid to the interior by zeroing the effective border
    assign pe = byp_q ? '0 : CW'(PAD);
    assign wl = byp_q ? CW'(FM_W) : CW'(GW);
    assign hl = byp_q ? CW'(FM_H) : CW'(GH);
    assign scan = state == SCAN;
    assign is_pad = (r < pe) | (r >= CW'(FM_H) + pe) | (c < pe) | (c >= CW'(FM_W) + pe);
    assign c_end = c == wl - CW'(1);
    assign r_end = r == hl - CW'(1);
    assign last_pos = scan & c_end & r_end;

    // interior addresses are consecutive in raster order, so a running counter replaces the multiply
    assign bram_rd_en = scan & ~is_pad;
    assign bram_rd_addr = bram_rd_en ? nxt_addr : held_addr;
    assign busy = state != IDLE;
    assign done = state == FIN;
    assign out_valid = vld_dl[BRAM_LAT-1];
    assign out_last = lst_dl[BRAM_LAT-1];

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? SCAN : IDLE;
            SCAN:    state_n = last_pos ? DRAIN : SCAN;
            DRAIN:   state_n = (dc == LW'(BRAM_LAT - 1)) ? FIN : DRAIN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r <= '0;
            c <= '0;
            dc <= '0;
            nxt_addr <= '0;
            held_addr <= '0;
        end else begin
            dc <= (state == DRAIN) ? dc + LW'(1) : '0;
            if (state == IDLE && start) begin
                r <= '0;
                c <= '0;
                nxt_addr <= base_addr;
            end else if (scan) begin
                c <= c_end ? '0 : c + CW'(1);
                r <= c_end ? r + CW'(1) : r;
                if (bram_rd_en) begin
                    nxt_addr <= nxt_addr + ADDR_W'(1);
                    held_addr <= nxt_addr;
                end
            end
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pad_dl <= '0;
            vld_dl <= '0;
            lst_dl <= '0;
        end else begin
            pad_dl[0] <= scan & is_pad;
            vld_dl[0] <= scan;
            lst_dl[0] <= last_pos;
            for (int i = 1; i < BRAM_LAT; i++) begin
                pad_dl[i] <= pad_dl[i-1];
                vld_dl[i] <= vld_dl[i-1];
                lst_dl[i] <= lst_dl[i-1];
            end
        end

    // idle cycles are zero-forced too, so BRAM_out reads 0 whenever out_valid is low
    mux_padding_2_1_L10_L16 #(.W(WD)) u_mux (
        .din (BRAM_out_without_padding),
        .sel (pad_dl[BRAM_LAT-1] | ~vld_dl[BRAM_LAT-1]),
        .dout(BRAM_out)
    );
endmodule

// File: tb/tb_padding_reader_l10.sv
// tb_padding_reader_l10: random-base frames on BRAM_LAT=1 and BRAM_LAT=3 instances against a grid model.
module tb_padding_reader_l10;
    localparam int WD = 256;
    localparam int MAXV = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [7:0] base = '0;
    logic pad_bypass = 1'b0;
    logic ren1, ren3, ov1, ov3, ol1, ol3, bz1, bz3, dn1, dn3;
    logic [7:0] ra1, ra3;
    logic [WD-1:0] bi1, bi3, bo1, bo3;
    logic [WD-1:0] p3[3];

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int nv[2], nrd[2], ndone[2], dcyc[2];
    logic [WD-1:0] wd[2][MAXV];
    logic ld[2][MAXV];
    int vc[2][MAXV];
    logic [7:0] ad[2][MAXV];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [WD-1:0] mk(input logic [7:0] a);
        return {1'b1, {(WD-9){1'b0}}, a};
    endfunction

    // BRAM returns a tagged copy of the address; non-read cycles return junk
    always @(posedge clk) bi1 <= ren1 ? mk(ra1) : {8{$urandom()}};
    always @(posedge clk) begin
        p3[0] <= ren3 ? mk(ra3) : {8{$urandom()}};
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign bi3 = p3[2];

    padding_reader_l10 #(.BRAM_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base),
`ifdef PAD_RUNTIME_BYPASS_EN
        .pad_bypass(pad_bypass),
`endif
        .bram_rd_en(ren1), .bram_rd_addr(ra1), .BRAM_out_without_padding(bi1),
        .BRAM_out(bo1), .out_valid(ov1), .out_last(ol1), .busy(bz1), .done(dn1)
    );

    padding_reader_l10 #(.BRAM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base),
`ifdef PAD_RUNTIME_BYPASS_EN
        .pad_bypass(pad_bypass),
`endif
        .bram_rd_en(ren3), .bram_rd_addr(ra3), .BRAM_out_without_padding(bi3),
        .BRAM_out(bo3), .out_valid(ov3), .out_last(ol3), .busy(bz3), .done(dn3)
    );

    // reference: position idx of the 16x16 grid (or 14x14 when bypassed)
    function automatic logic [WD-1:0] model(input int idx, input logic [7:0] b, input bit byp);
        int i, j;
        if (byp) return mk(b + 8'(idx));
        i = idx / 16;
        j = idx % 16;
        if (i < 1 || i > 14 || j < 1 || j > 14) return '0;
        return mk(b + 8'((i - 1) * 14 + (j - 1)));
    endfunction

    task automatic rec(input int d, input logic ov, input logic [WD-1:0] bo, input logic ol,
                       input logic ren, input logic [7:0] ra, input logic dn);
        if (ov) begin
            if (nv[d] < MAXV) begin
                wd[d][nv[d]] = bo;
                ld[d][nv[d]] = ol;
                vc[d][nv[d]] = cyc;
            end
            nv[d]++;
        end
        if (ren) begin
            if (nrd[d] < MAXV) ad[d][nrd[d]] = ra;
            nrd[d]++;
        end
        if (dn) begin
            ndone[d]++;
            dcyc[d] = cyc;
        end
    endtask

    always @(negedge clk) begin
        rec(0, ov1, bo1, ol1, ren1, ra1, dn1);
        rec(1, ov3, bo3, ol3, ren3, ra3, dn3);
    end

    task automatic clear_mon();
        for (int d = 0; d < 2; d++) begin
            nv[d] = 0;
            nrd[d] = 0;
            ndone[d] = 0;
            dcyc[d] = 0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({ren1, ov1, ol1, bz1, dn1, ren3, ov3, ol3, bz3, dn3} !== '0) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b want 0", {ren1, ov1, ol1, bz1, dn1, ren3, ov3, ol3, bz3, dn3});
        end
        vectors++;
        if ({ra1, ra3} !== '0 || bo1 !== '0 || bo3 !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got addr %h %h want 0", ra1, ra3);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_frame(input logic [7:0] b, input bit byp, input bit inject);
        int k, total, lat, n;
        bit fin;
        @(negedge clk);
        clear_mon();
        vectors++;
        if (bz1 !== 1'b0 || bz3 !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_busy: got %b%b want 00", bz1, bz3);
        end
        base = b;
        pad_bypass = byp;
        start = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        base = 8'($urandom);
        vectors++;
        if (bz1 !== 1'b1 || bz3 !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_rise: got %b%b want 11", bz1, bz3);
        end
        fin = 1'b0;
        for (int t = 0; t < 1200 && !fin; t++) begin
            @(negedge clk);
            if (inject) begin
                start = (t == 40);
                base = 8'($urandom);
            end
            fin = ndone[0] > 0 && ndone[1] > 0 && cyc >= dcyc[0] + 2 && cyc >= dcyc[1] + 2;
        end
        vectors++;
        if (!fin) begin
            miscompares++;
            $display("FAIL frame_timeout: got done %0d %0d want 1 1", ndone[0], ndone[1]);
        end
        vectors++;
        if (bz1 !== 1'b0 || bz3 !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_fall: got %b%b want 00", bz1, bz3);
        end
        total = byp ? 196 : 256;
        for (int d = 0; d < 2; d++) begin
            lat = d ? 3 : 1;
            vectors++;
            if (nv[d] != total) begin
                miscompares++;
                $display("FAIL out_count lat%0d: got %0d want %0d", lat, nv[d], total);
            end
            n = nv[d] < total ? nv[d] : total;
            for (int i = 0; i < n; i++) begin
                vectors++;
                if (wd[d][i] !== model(i, b, byp)) begin
                    miscompares++;
                    $display("FAIL word lat%0d idx%0d: got %h want %h", lat, i, wd[d][i], model(i, b, byp));
                end
                vectors++;
                if (ld[d][i] !== (i == total - 1)) begin
                    miscompares++;
                    $display("FAIL last lat%0d idx%0d: got %b want %b", lat, i, ld[d][i], i == total - 1);
                end
                vectors++;
                if (vc[d][i] != k + lat + i) begin
                    miscompares++;
                    $display("FAIL out_cycle lat%0d idx%0d: got %0d want %0d", lat, i, vc[d][i], k + lat + i);
                end
            end
            vectors++;
            if (nrd[d] != 196) begin
                miscompares++;
                $display("FAIL rd_count lat%0d: got %0d want 196", lat, nrd[d]);
            end
            n = nrd[d] < 196 ? nrd[d] : 196;
            for (int i = 0; i < n; i++) begin
                vectors++;
                if (ad[d][i] !== b + 8'(i)) begin
                    miscompares++;
                    $display("FAIL rd_addr lat%0d n%0d: got %h want %h", lat, i, ad[d][i], b + 8'(i));
                end
            end
            vectors++;
            if (ndone[d] != 1 || dcyc[d] != k + lat + total) begin
                miscompares++;
                $display("FAIL done lat%0d: got %0d pulses at %0d want 1 at %0d", lat, ndone[d], dcyc[d], k + lat + total);
            end
        end
    endtask

    task automatic test_wrap();
        test_frame(8'hF0, 1'b0, 1'b0);
        vectors++;
        if (ad[0][195] !== 8'hB3 || ad[1][195] !== 8'hB3) begin
            miscompares++;
            $display("FAIL wrap_addr: got %h %h want b3", ad[0][195], ad[1][195]);
        end
        vectors++;
        if (wd[0][238] !== mk(8'hB3)) begin
            miscompares++;
            $display("FAIL wrap_word: got %h want %h", wd[0][238], mk(8'hB3));
        end
    endtask

    task automatic test_start_in_scan();
        test_frame(8'($urandom), 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int t, snap0, snap1;
        @(negedge clk);
        clear_mon();
        base = 8'($urandom);
        pad_bypass = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (t = 0; t < 600 && nv[0] < 100; t++) @(negedge clk);
        vectors++;
        if (nv[0] < 100) begin
            miscompares++;
            $display("FAIL reach_100: got %0d outputs want 100", nv[0]);
        end
        #2 rst = 1'b1;
        #1;
        snap0 = nv[0];
        snap1 = nv[1];
        vectors++;
        if ({ren1, ov1, ol1, bz1, dn1, ren3, ov3, ol3, bz3, dn3} !== '0 || {ra1, ra3} !== '0) begin
            miscompares++;
            $display("FAIL abort_ctl: got %b addr %h %h want 0", {ren1, ov1, ol1, bz1, dn1, ren3, ov3, ol3, bz3, dn3}, ra1, ra3);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bo1 !== '0 || bo3 !== '0 || ov1 !== 1'b0 || ov3 !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_data: got valid %b%b want 00 and zero words", ov1, ov3);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        vectors++;
        if (ndone[0] != 0 || ndone[1] != 0 || nv[0] != snap0 || nv[1] != snap1) begin
            miscompares++;
            $display("FAIL abort_quiet: got done %0d %0d outputs +%0d +%0d want 0", ndone[0], ndone[1], nv[0] - snap0, nv[1] - snap1);
        end
        test_frame(8'($urandom), 1'b0, 1'b0);
    endtask

`ifdef PAD_RUNTIME_BYPASS_EN
    task automatic test_bypass();
        logic [7:0] b;
        b = 8'($urandom);
        test_frame(b, 1'b1, 1'b0);
        vectors++;
        if (wd[0][0] !== mk(b) || wd[1][0] !== mk(b)) begin
            miscompares++;
            $display("FAIL bypass_first: got %h want %h", wd[0][0], mk(b));
        end
        test_frame(8'($urandom), 1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_frame(8'h00, 1'b0, 1'b0);
        repeat (2) test_frame(8'($urandom), 1'b0, 1'b0);
        test_wrap();
        test_start_in_scan();
        test_reset_mid();
`ifdef PAD_RUNTIME_BYPASS_EN
        test_bypass();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
